// File: rtl/banner_scroller_if.sv
// Display-side row handshake between banner_scroller and the display driver.
// The scroller drives a windowed row plus its index; the driver answers with ready.
interface banner_scroller_if #(
    parameter int WIN = 16
) ();
    logic           row_valid;
    logic           row_ready;
    logic [WIN-1:0] row_data;
    logic [4:0]     row_index;
    logic           frame_start;

    modport master (
        output row_valid,
        output row_data,
        output row_index,
        output frame_start,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_data,
        input  row_index,
        input  frame_start,
        output row_ready
    );
endinterface

// File: rtl/banner_scroller.sv
// Banner scroller: walks the banner ROM once per frame, cuts a WIN-column
// window at the current scroll offset out of each row and hands the rows to
// the display over a valid/ready handshake. The offset advances one column
// every FRAMES_PER_STEP frames and wraps seamlessly across the banner edge.
module banner_scroller #(
    parameter int BANNER_W        = 70,
    parameter int ROWS            = 15,
    parameter int WIN             = 16,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic [4:0]           rom_addr,
    input  logic [BANNER_W-1:0]  rom_data,
    output logic [6:0]           offset,
    banner_scroller_if.master    row_if
);

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    // Frame counter sized so that FRAMES_PER_STEP = 1 still gets one bit
    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [4:0]      ROW_LAST   = 5'(ROWS - 1);
    localparam logic [6:0]      OFFSET_MAX = 7'(BANNER_W - 1);

    // The row is duplicated so a window that runs past column BANNER_W-1
    // simply continues into the copy, giving the wrap with one part-select.
    localparam int DBL_W = 2 * BANNER_W;
    localparam int IDX_W = $clog2(DBL_W);

    logic [1:0]          state_r,       state_s;
    logic [4:0]          rom_addr_r,    rom_addr_s;
    logic [4:0]          row_cnt_r,     row_cnt_s;
    logic                row_valid_r,   row_valid_s;
    logic [WIN-1:0]      row_data_r,    row_data_s;
    logic [4:0]          row_index_r,   row_index_s;
    logic                frame_start_r, frame_start_s;
    logic [6:0]          offset_r,      offset_s;
    logic [FC_W-1:0]     frame_cnt_r,   frame_cnt_s;

    logic [DBL_W-1:0]    dbl_row_s;
    logic [IDX_W-1:0]    win_base_s;
    logic [WIN-1:0]      window_s;

    // Window extraction: column c of the banner is ROM bit BANNER_W-1-c, so
    // the leftmost visible column sits at the top of the doubled row minus offset.
    always_comb begin
        dbl_row_s  = {rom_data, rom_data};
        win_base_s = IDX_W'(DBL_W - 1) - IDX_W'(offset_r);
        window_s   = dbl_row_s[win_base_s -: WIN];
    end

    // Next-state and next-output logic for the row sequencer.
    always_comb begin
        state_s       = state_r;
        rom_addr_s    = rom_addr_r;
        row_cnt_s     = row_cnt_r;
        row_valid_s   = row_valid_r;
        row_data_s    = row_data_r;
        row_index_s   = row_index_r;
        frame_start_s = frame_start_r;
        offset_s      = offset_r;
        frame_cnt_s   = frame_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    row_cnt_s  = 5'd0;
                    rom_addr_s = 5'd0;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // ROM registers the address during this cycle
                state_s = ST_LATCH;
            end

            ST_LATCH: begin
                row_data_s    = window_s;
                row_index_s   = row_cnt_r;
                frame_start_s = (row_cnt_r == 5'd0);
                row_valid_s   = 1'b1;
                state_s       = ST_PRESENT;
            end

            ST_PRESENT: begin
                if (row_valid_r && row_if.row_ready) begin
                    row_valid_s   = 1'b0;
                    frame_start_s = 1'b0;
                    if (row_cnt_r == ROW_LAST) begin
                        state_s = ST_IDLE;
                        // Frame-end update; offset only moves between frames
                        if (frame_cnt_r == FC_LAST) begin
                            frame_cnt_s = {FC_W{1'b0}};
                            if (offset_r == OFFSET_MAX) begin
                                offset_s = 7'd0;
                            end else begin
                                offset_s = offset_r + 7'd1;
                            end
                        end else begin
                            frame_cnt_s = frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        row_cnt_s  = row_cnt_r + 5'd1;
                        rom_addr_s = row_cnt_r + 5'd1;
                        state_s    = ST_ISSUE;
                    end
                end else begin
                    // Stall: everything holds, including the ROM address
                    state_s = ST_PRESENT;
                end
            end

            default: begin
                state_s       = ST_IDLE;
                row_valid_s   = 1'b0;
                frame_start_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any row in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rom_addr_r    <= 5'd0;
            row_cnt_r     <= 5'd0;
            row_valid_r   <= 1'b0;
            row_data_r    <= {WIN{1'b0}};
            row_index_r   <= 5'd0;
            frame_start_r <= 1'b0;
            offset_r      <= 7'd0;
            frame_cnt_r   <= {FC_W{1'b0}};
        end else begin
            state_r       <= state_s;
            rom_addr_r    <= rom_addr_s;
            row_cnt_r     <= row_cnt_s;
            row_valid_r   <= row_valid_s;
            row_data_r    <= row_data_s;
            row_index_r   <= row_index_s;
            frame_start_r <= frame_start_s;
            offset_r      <= offset_s;
            frame_cnt_r   <= frame_cnt_s;
        end
    end

    assign rom_addr           = rom_addr_r;
    assign offset             = offset_r;
    assign row_if.row_valid   = row_valid_r;
    assign row_if.row_data    = row_data_r;
    assign row_if.row_index   = row_index_r;
    assign row_if.frame_start = frame_start_r;

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: a behavioural ROM with random rows feeds the DUT,
// and every delivered row is compared against a window computed directly from
// the banner column rule with the offset derived from completed-frame count.
module tb_banner_scroller;
    localparam int BANNER_W = 70;
    localparam int ROWS     = 15;
    localparam int WIN      = 16;
    localparam int FPS      = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [4:0]          rom_addr;
    logic [BANNER_W-1:0] rom_data;
    logic [6:0]          offset;

    banner_scroller_if #(.WIN(WIN)) row_if ();

    banner_scroller #(
        .BANNER_W(BANNER_W), .ROWS(ROWS), .WIN(WIN), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .offset   (offset),
        .row_if   (row_if)
    );

    always #5 clk = ~clk;

    // Banner ROM model: one-cycle registered read
    logic [BANNER_W-1:0] rom_mem [ROWS];
    always @(posedge clk) begin
        if (rom_addr < 5'(ROWS)) rom_data <= rom_mem[rom_addr];
        else                     rom_data <= '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ref_frames = 0;

    function automatic int ref_offset();
        return (ref_frames / FPS) % BANNER_W;
    endfunction

    function automatic logic [WIN-1:0] exp_window(input int row, input int off);
        logic [WIN-1:0] w;
        int col;
        w = '0;
        for (int j = 0; j < WIN; j++) begin
            col = (off + j) % BANNER_W;
            w[WIN-1-j] = rom_mem[row][BANNER_W-1-col];
        end
        return w;
    endfunction

    // Runs one frame, checking every row; optional stall, enable drop or reset abort.
    task automatic run_frame(input int stall_row, input int stall_len, input int drop_row,
                             input int abort_row, input bit rand_stall,
                             output int first_cyc);
        logic [WIN-1:0] exp_d;
        int waited;
        int stall;
        first_cyc = 0;
        for (int r = 0; r < ROWS; r++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (row_if.row_valid !== 1'b1 && waited < 20);
            checks++;
            if (row_if.row_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_timeout row=%0d got=%b exp=1", r, row_if.row_valid);
                return;
            end
            checks++;
            if (waited !== ((r == 0) ? 3 : 2)) begin
                errors++;
                $display("FAIL row_latency row=%0d got=%0d exp=%0d", r, waited, (r == 0) ? 3 : 2);
            end
            if (r == 0) first_cyc = cyc;
            exp_d = exp_window(r, ref_offset());
            checks++;
            if (row_if.row_data !== exp_d) begin
                errors++;
                $display("FAIL row_data row=%0d off=%0d got=%b exp=%b", r, ref_offset(), row_if.row_data, exp_d);
            end
            checks++;
            if (row_if.row_index !== 5'(r)) begin
                errors++;
                $display("FAIL row_index got=%0d exp=%0d", row_if.row_index, r);
            end
            checks++;
            if (row_if.frame_start !== (r == 0)) begin
                errors++;
                $display("FAIL frame_start row=%0d got=%b exp=%b", r, row_if.frame_start, (r == 0));
            end
            checks++;
            if (offset !== 7'(ref_offset())) begin
                errors++;
                $display("FAIL offset row=%0d got=%0d exp=%0d", r, offset, ref_offset());
            end
            checks++;
            if (rom_addr !== 5'(r)) begin
                errors++;
                $display("FAIL rom_addr_present row=%0d got=%0d exp=%0d", r, rom_addr, r);
            end
            if (r == drop_row) enable = 1'b0;
            if (r == abort_row) begin
                rst = 1'b1;
                @(negedge clk);
                checks++;
                if (row_if.row_valid !== 1'b0 || rom_addr !== 5'd0 || offset !== 7'd0 ||
                    row_if.frame_start !== 1'b0 || row_if.row_data !== '0) begin
                    errors++;
                    $display("FAIL reset_abort got valid=%b addr=%0d off=%0d fs=%b data=%h exp 0/0/0/0/0",
                             row_if.row_valid, rom_addr, offset, row_if.frame_start, row_if.row_data);
                end
                rst = 1'b0;
                ref_frames = 0;
                return;
            end
            stall = (r == stall_row) ? stall_len : (rand_stall ? int'($urandom_range(0, 3)) : 0);
            if (stall > 0) begin
                row_if.row_ready = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    checks++;
                    if (row_if.row_valid !== 1'b1 || row_if.row_data !== exp_d || rom_addr !== 5'(r)) begin
                        errors++;
                        $display("FAIL stall_hold row=%0d got valid=%b data=%b addr=%0d exp 1/%b/%0d",
                                 r, row_if.row_valid, row_if.row_data, rom_addr, exp_d, r);
                    end
                end
            end
            row_if.row_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (row_if.row_valid !== 1'b0 || rom_addr !== 5'((r == ROWS-1) ? r : r + 1)) begin
                errors++;
                $display("FAIL accept row=%0d got valid=%b addr=%0d exp 0/%0d",
                         r, row_if.row_valid, rom_addr, (r == ROWS-1) ? r : r + 1);
            end
            if (rand_stall) row_if.row_ready = 1'($urandom);
        end
        ref_frames++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        row_if.row_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (row_if.row_valid !== 1'b0 || rom_addr !== 5'd0 || offset !== 7'd0 ||
            row_if.row_data !== '0 || row_if.row_index !== 5'd0 || row_if.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%b addr=%0d off=%0d data=%h idx=%0d fs=%b exp all 0",
                     row_if.row_valid, rom_addr, offset, row_if.row_data, row_if.row_index, row_if.frame_start);
        end
        rst = 1'b0;
        ref_frames = 0;
        @(negedge clk);
        checks++;
        if (row_if.row_valid !== 1'b0 || rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL idle_no_enable got valid=%b addr=%0d exp 0/0", row_if.row_valid, rom_addr);
        end
    endtask

    task automatic test_first_frame();
        int fc;
        enable = 1'b1;
        row_if.row_ready = 1'b1;
        run_frame(-1, 0, -1, -1, 1'b0, fc);
    endtask

    task automatic test_random_frames();
        int fc;
        for (int f = 0; f < 5; f++) run_frame(-1, 0, -1, -1, 1'b1, fc);
    endtask

    task automatic test_offset_step();
        int fc;
        int prev_fc;
        prev_fc = -1;
        row_if.row_ready = 1'b1;
        while (ref_frames < 280) begin
            run_frame(-1, 0, -1, -1, 1'b0, fc);
            if (prev_fc >= 0) begin
                checks++;
                if (fc - prev_fc !== 46) begin
                    errors++;
                    $display("FAIL frame_length got=%0d exp=46", fc - prev_fc);
                end
            end
            prev_fc = fc;
            if (ref_frames == 264) begin
                checks++;
                if (offset !== 7'd66) begin
                    errors++;
                    $display("FAIL offset_264 got=%0d exp=66", offset);
                end
            end
        end
        checks++;
        if (offset !== 7'd0) begin
            errors++;
            $display("FAIL offset_wrap_280 got=%0d exp=0", offset);
        end
    endtask

    task automatic test_backpressure();
        int fc;
        run_frame(7, 10, -1, -1, 1'b0, fc);
    endtask

    task automatic test_enable_drop();
        int fc;
        int seen;
        seen = 0;
        run_frame(-1, 0, 5, -1, 1'b0, fc);
        repeat (12) begin
            @(negedge clk);
            if (row_if.row_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || rom_addr !== 5'(ROWS-1)) begin
            errors++;
            $display("FAIL enable_drop_idle got valid_cycles=%0d addr=%0d exp 0/%0d", seen, rom_addr, ROWS-1);
        end
        checks++;
        if (offset !== 7'(ref_offset())) begin
            errors++;
            $display("FAIL enable_drop_offset got=%0d exp=%0d", offset, ref_offset());
        end
    endtask

    task automatic test_reset_mid();
        int fc;
        int guard;
        guard = 0;
        enable = 1'b1;
        while (ref_offset() == 0 && guard < 8) begin
            run_frame(-1, 0, -1, -1, 1'b0, fc);
            guard++;
        end
        run_frame(-1, 0, -1, 9, 1'b0, fc);
        run_frame(-1, 0, -1, -1, 1'b0, fc);
        checks++;
        if (offset !== 7'd0) begin
            errors++;
            $display("FAIL offset_after_reset_frame got=%0d exp=0", offset);
        end
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) rom_mem[i] = {6'($urandom), $urandom, $urandom};
        rom_mem[3] = {BANNER_W{1'b1}};
        rom_mem[4] = {{(BANNER_W/2){1'b1}}, {(BANNER_W/2){1'b0}}};
        rom_mem[7] = {1'b1, {(BANNER_W-2){1'b0}}, 1'b1};
        test_reset();
        test_first_frame();
        test_random_frames();
        test_offset_step();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
